// File: rtl/interrupt_csr_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the interrupt CSR bank and trap sequencer.
package interrupt_csr_ctrl_pkg;

    localparam logic [1:0] CSR_STATUS  = 2'd0;
    localparam logic [1:0] CSR_INTMASK = 2'd1;
    localparam logic [1:0] CSR_SCAUSE  = 2'd2;
    localparam logic [1:0] CSR_SIDX    = 2'd3;

    localparam int unsigned STATUS_IE  = 0;
    localparam int unsigned STATUS_PIE = 1;

    typedef enum logic [1:0] {
        StNormal,
        StEnter,
        StHandler,
        StReturn
    } state_e;

    // Lowest set bit wins; an all-zero vector yields index 0.
    function automatic logic [2:0] f_lowest_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/interrupt_csr_ctrl_if.sv
// CSR bus, interrupt lines and pipeline-control signals between the core and the trap sequencer.
interface interrupt_csr_ctrl_if #(
    parameter int unsigned XLEN = 32
);
    logic [7:0]      irq_in;
    logic            csr_we;
    logic [1:0]      csr_addr;
    logic [7:0]      csr_wdata;
    logic [7:0]      csr_rdata;
    logic            take_interrupt;
    logic [XLEN-1:0] ex_pc;
    logic            eret_ex;
    logic [7:0]      status;
    logic [7:0]      intmask;
    logic [7:0]      scause;
    logic            in_exception;
    logic            flush;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic [XLEN-1:0] sepc;

    modport slave (
        input  irq_in, csr_we, csr_addr, csr_wdata, take_interrupt, ex_pc, eret_ex,
        output csr_rdata, status, intmask, scause, in_exception, flush, redirect_valid,
               redirect_pc, sepc
    );

    modport master (
        output irq_in, csr_we, csr_addr, csr_wdata, take_interrupt, ex_pc, eret_ex,
        input  csr_rdata, status, intmask, scause, in_exception, flush, redirect_valid,
               redirect_pc, sepc
    );
endinterface

// File: rtl/interrupt_csr_ctrl_irq_edge_capture.sv
// Rising-edge capture of interrupt lines into the pending-cause register (W1C, set wins).
module irq_edge_capture #(
    parameter int unsigned NIRQ = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NIRQ-1:0] i_irq,
    input  logic            i_clr_we,
    input  logic [NIRQ-1:0] i_clr_mask,
    output logic [NIRQ-1:0] o_scause
);

    logic [NIRQ-1:0] r_irq_prev;
    logic [NIRQ-1:0] r_scause;
    logic [NIRQ-1:0] w_rise;
    logic [NIRQ-1:0] w_clr;

    assign w_rise = i_irq & ~r_irq_prev;
    assign w_clr  = i_clr_we ? i_clr_mask : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq_prev <= '0;
            r_scause   <= '0;
        end else begin
            r_irq_prev <= i_irq;
            r_scause   <= (r_scause & ~w_clr) | w_rise;
        end
    end

    assign o_scause = r_scause;

endmodule

// File: rtl/interrupt_csr_ctrl.sv
// Interrupt CSR bank plus trap entry/return sequencer driving pipeline flush and redirect.
module interrupt_csr_ctrl
    import interrupt_csr_ctrl_pkg::*;
#(
    parameter int unsigned     XLEN          = 32,
    parameter int unsigned     NIRQ          = 8,
    parameter logic [XLEN-1:0] VECTOR_BASE   = 32'h0000_0010,
    parameter int unsigned     VECTOR_STRIDE = 4
) (
    input logic                 clk,
    input logic                 rst,
    interrupt_csr_ctrl_if.slave bus
);

    state_e          r_state;
    logic [1:0]      r_status;
    logic [7:0]      r_intmask;
    logic [2:0]      r_sidx;
    logic [XLEN-1:0] r_sepc;
    logic            r_in_exception;
    logic            r_flush;
    logic            r_redirect_valid;
    logic [XLEN-1:0] r_redirect_pc;

    logic [NIRQ-1:0] w_scause;
    logic [2:0]      w_sidx;
    logic [XLEN-1:0] w_vector;
    logic            w_scause_clr;

    assign w_scause_clr = bus.csr_we && (bus.csr_addr == CSR_SCAUSE);

    irq_edge_capture #(
        .NIRQ (NIRQ)
    ) u_irq_edge_capture (
        .clk        (clk),
        .rst        (rst),
        .i_irq      (bus.irq_in),
        .i_clr_we   (w_scause_clr),
        .i_clr_mask (bus.csr_wdata),
        .o_scause   (w_scause)
    );

    assign w_sidx   = f_lowest_idx(w_scause & ~r_intmask);
    assign w_vector = VECTOR_BASE + XLEN'(VECTOR_STRIDE) * XLEN'(w_sidx);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= StNormal;
            r_status         <= '0;
            r_intmask        <= '0;
            r_sidx           <= '0;
            r_sepc           <= '0;
            r_in_exception   <= 1'b0;
            r_flush          <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            if (bus.csr_we && bus.csr_addr == CSR_STATUS)  r_status  <= bus.csr_wdata[1:0];
            if (bus.csr_we && bus.csr_addr == CSR_INTMASK) r_intmask <= bus.csr_wdata;
            r_flush          <= 1'b0;
            r_redirect_valid <= 1'b0;
            // Trap updates below are written later so they override a same-cycle STATUS write.
            unique case (r_state)
                StNormal: begin
                    if (bus.take_interrupt) begin
                        r_state              <= StEnter;
                        r_sepc               <= bus.ex_pc;
                        r_sidx               <= w_sidx;
                        r_status[STATUS_PIE] <= r_status[STATUS_IE];
                        r_status[STATUS_IE]  <= 1'b0;
                        r_in_exception       <= 1'b1;
                        r_flush              <= 1'b1;
                        r_redirect_valid     <= 1'b1;
                        r_redirect_pc        <= w_vector;
                    end
                end
                StEnter: r_state <= StHandler;
                StHandler: begin
                    if (bus.eret_ex) begin
                        r_state              <= StReturn;
                        r_status[STATUS_PIE] <= r_status[STATUS_PIE];
                        r_status[STATUS_IE]  <= r_status[STATUS_PIE];
                        r_flush              <= 1'b1;
                        r_redirect_valid     <= 1'b1;
                        r_redirect_pc        <= r_sepc;
                    end
                end
                StReturn: begin
                    r_state        <= StNormal;
                    r_in_exception <= 1'b0;
                end
                default: r_state <= StNormal;
            endcase
        end
    end

    always_comb begin
        bus.csr_rdata = '0;
        unique case (bus.csr_addr)
            CSR_STATUS:  bus.csr_rdata = {6'b0, r_status};
            CSR_INTMASK: bus.csr_rdata = r_intmask;
            CSR_SCAUSE:  bus.csr_rdata = w_scause;
            CSR_SIDX:    bus.csr_rdata = {5'b0, r_sidx};
            default:     bus.csr_rdata = '0;
        endcase
    end

    assign bus.status         = {6'b0, r_status};
    assign bus.intmask        = r_intmask;
    assign bus.scause         = w_scause;
    assign bus.in_exception   = r_in_exception;
    assign bus.flush          = r_flush;
    assign bus.redirect_valid = r_redirect_valid;
    assign bus.redirect_pc    = r_redirect_pc;
    assign bus.sepc           = r_sepc;

endmodule

// File: tb/tb_interrupt_csr_ctrl.sv
// Directed bench for interrupt_csr_ctrl: expectations queued with each stimulus step, popped on check.
module tb_interrupt_csr_ctrl;

    logic clk;
    logic rst;

    interrupt_csr_ctrl_if #(.XLEN(32)) bus ();

    interrupt_csr_ctrl #(
        .XLEN          (32),
        .NIRQ          (8),
        .VECTOR_BASE   (32'h0000_0010),
        .VECTOR_STRIDE (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t q_exp[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic expect_val(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        q_exp.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (q_exp.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=%0h required=<none>", obs);
        end else begin
            e = q_exp.pop_front();
            assert (obs === e.val) else begin
                failures++;
                $error("FAIL %s observed=%0h required=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_csr(input logic [1:0] addr, output logic [7:0] data);
        bus.csr_addr = addr;
        #1;
        data = bus.csr_rdata;
    endtask

    logic [7:0] rd;

    initial begin
        rst                = 1'b1;
        bus.irq_in         = '0;
        bus.csr_we         = 1'b0;
        bus.csr_addr       = '0;
        bus.csr_wdata      = '0;
        bus.take_interrupt = 1'b0;
        bus.ex_pc          = '0;
        bus.eret_ex        = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        expect_val("rst_status", 32'h0);
        expect_val("rst_intmask", 32'h0);
        expect_val("rst_scause", 32'h0);
        expect_val("rst_sepc", 32'h0);
        expect_val("rst_inexc", 32'h0);
        expect_val("rst_flush", 32'h0);
        expect_val("rst_rvalid", 32'h0);
        expect_val("rst_sidx", 32'h0);
        check(32'(bus.status));
        check(32'(bus.intmask));
        check(32'(bus.scause));
        check(bus.sepc);
        check(32'(bus.in_exception));
        check(32'(bus.flush));
        check(32'(bus.redirect_valid));
        read_csr(2'd3, rd);
        check(32'(rd));

        // Basic entry
        bus.csr_we = 1'b1; bus.csr_addr = 2'd0; bus.csr_wdata = 8'h01;
        expect_val("wr_status", 32'h01);
        tick();
        bus.csr_we = 1'b0;
        check(32'(bus.status));
        bus.irq_in = 8'h04;
        expect_val("irq2_pending", 32'h04);
        tick();
        bus.irq_in = 8'h00;
        check(32'(bus.scause));
        bus.take_interrupt = 1'b1; bus.ex_pc = 32'h100;
        expect_val("entry_flush", 32'h1);
        expect_val("entry_rvalid", 32'h1);
        expect_val("entry_rpc", 32'h18);
        expect_val("entry_sepc", 32'h100);
        expect_val("entry_status", 32'h02);
        expect_val("entry_inexc", 32'h1);
        tick();
        bus.take_interrupt = 1'b0;
        check(32'(bus.flush));
        check(32'(bus.redirect_valid));
        check(bus.redirect_pc);
        check(bus.sepc);
        check(32'(bus.status));
        check(32'(bus.in_exception));
        expect_val("handler_flush", 32'h0);
        expect_val("handler_inexc", 32'h1);
        tick();
        check(32'(bus.flush));
        check(32'(bus.in_exception));

        // take_interrupt ignored in HANDLER
        bus.take_interrupt = 1'b1; bus.ex_pc = 32'h200;
        expect_val("ign_take_flush", 32'h0);
        expect_val("ign_take_sepc", 32'h100);
        expect_val("ign_take_inexc", 32'h1);
        expect_val("sidx_src2", 32'h2);
        tick();
        bus.take_interrupt = 1'b0;
        check(32'(bus.flush));
        check(bus.sepc);
        check(32'(bus.in_exception));
        read_csr(2'd3, rd);
        check(32'(rd));

        // Return
        bus.eret_ex = 1'b1;
        expect_val("ret_flush", 32'h1);
        expect_val("ret_rvalid", 32'h1);
        expect_val("ret_rpc", 32'h100);
        expect_val("ret_status", 32'h03);
        expect_val("ret_inexc_hold", 32'h1);
        tick();
        bus.eret_ex = 1'b0;
        check(32'(bus.flush));
        check(32'(bus.redirect_valid));
        check(bus.redirect_pc);
        check(32'(bus.status));
        check(32'(bus.in_exception));
        expect_val("ret_inexc_fall", 32'h0);
        expect_val("ret_flush_drop", 32'h0);
        tick();
        check(32'(bus.in_exception));
        check(32'(bus.flush));

        // eret_ex ignored in NORMAL
        bus.eret_ex = 1'b1;
        expect_val("ign_eret_flush", 32'h0);
        expect_val("ign_eret_inexc", 32'h0);
        expect_val("ign_eret_status", 32'h03);
        tick();
        bus.eret_ex = 1'b0;
        check(32'(bus.flush));
        check(32'(bus.in_exception));
        check(32'(bus.status));

        // W1C vs set
        bus.csr_we = 1'b1; bus.csr_addr = 2'd2; bus.csr_wdata = 8'h04;
        expect_val("w1c_clear", 32'h00);
        tick();
        check(32'(bus.scause));
        bus.irq_in = 8'h04;
        expect_val("w1c_set_wins", 32'h04);
        tick();
        check(32'(bus.scause));
        bus.irq_in = 8'h00;
        expect_val("w1c_later_clear", 32'h00);
        tick();
        bus.csr_we = 1'b0;
        check(32'(bus.scause));

        // Mask priority
        bus.irq_in = 8'h0A;
        tick();
        bus.irq_in = 8'h00;
        bus.csr_we = 1'b1; bus.csr_addr = 2'd1; bus.csr_wdata = 8'h02;
        expect_val("mask_scause", 32'h0A);
        expect_val("mask_intmask", 32'h02);
        tick();
        bus.csr_we = 1'b0;
        check(32'(bus.scause));
        read_csr(2'd1, rd);
        check(32'(rd));
        bus.take_interrupt = 1'b1; bus.ex_pc = 32'h300;
        expect_val("mask_rpc", 32'h1C);
        expect_val("mask_sepc", 32'h300);
        expect_val("mask_status", 32'h02);
        expect_val("mask_sidx", 32'h3);
        tick();
        bus.take_interrupt = 1'b0;
        check(bus.redirect_pc);
        check(bus.sepc);
        check(32'(bus.status));
        read_csr(2'd3, rd);
        check(32'(rd));

        // Reset while in ENTER
        rst = 1'b1;
        expect_val("mrst_flush", 32'h0);
        expect_val("mrst_rvalid", 32'h0);
        expect_val("mrst_inexc", 32'h0);
        expect_val("mrst_status", 32'h0);
        expect_val("mrst_intmask", 32'h0);
        expect_val("mrst_scause", 32'h0);
        expect_val("mrst_sepc", 32'h0);
        expect_val("mrst_sidx", 32'h0);
        tick();
        check(32'(bus.flush));
        check(32'(bus.redirect_valid));
        check(32'(bus.in_exception));
        check(32'(bus.status));
        check(32'(bus.intmask));
        check(32'(bus.scause));
        check(bus.sepc);
        read_csr(2'd3, rd);
        check(32'(rd));
        rst = 1'b0;
        expect_val("post_rst_rvalid", 32'h0);
        expect_val("post_rst_inexc", 32'h0);
        tick();
        check(32'(bus.redirect_valid));
        check(32'(bus.in_exception));

        // Trap update overrides same-cycle STATUS write
        bus.csr_we = 1'b1; bus.csr_addr = 2'd0; bus.csr_wdata = 8'h01;
        bus.irq_in = 8'h01;
        tick();
        bus.irq_in = 8'h00;
        bus.csr_wdata = 8'hFC;
        bus.take_interrupt = 1'b1; bus.ex_pc = 32'h400;
        expect_val("prio_status", 32'h02);
        expect_val("prio_rpc", 32'h10);
        tick();
        bus.csr_we = 1'b0;
        bus.take_interrupt = 1'b0;
        check(32'(bus.status));
        check(bus.redirect_pc);

        if (q_exp.size() != 0) begin
            failures++;
            $error("FAIL scoreboard_leftover observed=%0d required=0", q_exp.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
